// File: rtl/flash_pp_page_feeder.sv
// flash_pp_page_feeder
// Gathers a host byte stream into flash pages and hands page-program jobs to
// flash_pp_ctrl. Two PAGE_BYTES banks run ping-pong: the host fills one bank
// while the flash controller drains the other. A job never crosses a flash page
// boundary. An unaligned session base therefore produces a short first job.
//
// Ports
//   system_clk, system_reset_n : clock, asynchronous active-low reset
//   start, base_addr, mode_in  : open a session at base_addr (mode 0 PP, 1 PPx4)
//   wr_en, wr_data, wr_ready   : host byte stream; wr_ready = fill bank free
//   flush                      : commit a partially filled bank
//   pp_key, pp_addr, pp_num,
//   pp_mode, pp_data           : job trigger, job parameters and current byte
//   data_req, pp_done          : byte advance and job completion from the controller
//   busy, page_cnt, overflow   : status (session/jobs active, jobs done, byte dropped)
module flash_pp_page_feeder #(
    parameter int PAGE_BYTES = 256,
    parameter int ADDR_W     = 32
) (
    input  logic              system_clk,
    input  logic              system_reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              mode_in,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    input  logic              flush,
    output logic              pp_key,
    output logic [ADDR_W-1:0] pp_addr,
    output logic [8:0]        pp_num,
    output logic              pp_mode,
    output logic [7:0]        pp_data,
    input  logic              data_req,
    input  logic              pp_done,
    output logic              busy,
    output logic [15:0]       page_cnt,
    output logic              overflow
);

    localparam int IDX_W = $clog2(PAGE_BYTES);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CAP_MAX = CNT_W'(PAGE_BYTES);

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_KEY  = 2'd1,
        D_WAIT = 2'd2
    } drain_state_t;

    logic [7:0]        mem_r [2][PAGE_BYTES];
    logic [1:0]        bank_full_r;
    logic [ADDR_W-1:0] bank_addr_r [2];
    logic [CNT_W-1:0]  bank_cnt_r [2];

    logic              session_r;
    logic              mode_r;
    logic              overflow_r;
    logic              fill_bank_r;
    logic [CNT_W-1:0]  fill_cnt_r;
    logic [ADDR_W-1:0] wr_addr_r;

    drain_state_t      drain_state_r;
    drain_state_t      drain_state_s;
    logic              drain_bank_r;
    logic [IDX_W-1:0]  rd_idx_r;
    logic [IDX_W-1:0]  rd_idx_s;
    logic              load_s;
    logic              free_s;

    logic              pp_key_r;
    logic [ADDR_W-1:0] pp_addr_r;
    logic [8:0]        pp_num_r;
    logic              pp_mode_r;
    logic [7:0]        pp_data_r;
    logic [15:0]       page_cnt_r;

    logic              start_ok_s;
    logic              wr_ready_s;
    logic              accept_s;
    logic [CNT_W-1:0]  cnt_after_s;
    logic [CNT_W-1:0]  cap_s;
    logic              commit_s;

    // Fill-side decode: a bank is committed when it reaches the bytes left in
    // the current flash page, or on flush with at least one byte (including a
    // byte written in the same cycle as the flush).
    always_comb begin
        start_ok_s  = start && (bank_full_r == 2'b00) && (drain_state_r == D_IDLE);
        wr_ready_s  = session_r && !bank_full_r[fill_bank_r];
        accept_s    = wr_en && wr_ready_s;
        cnt_after_s = fill_cnt_r + CNT_W'(accept_s);
        cap_s       = CAP_MAX - CNT_W'(wr_addr_r[IDX_W-1:0]);
        commit_s    = !start_ok_s && wr_ready_s &&
                      ((cnt_after_s == cap_s) ||
                       (flush && (cnt_after_s != {CNT_W{1'b0}})));
    end

    // Drain FSM next state; banks drain in the same alternating order they fill.
    always_comb begin
        drain_state_s = drain_state_r;
        rd_idx_s      = rd_idx_r;
        load_s        = 1'b0;
        free_s        = 1'b0;
        case (drain_state_r)
            D_IDLE: begin
                if (bank_full_r[drain_bank_r]) begin
                    drain_state_s = D_KEY;
                    rd_idx_s      = {IDX_W{1'b0}};
                    load_s        = 1'b1;
                end else begin
                    drain_state_s = D_IDLE;
                end
            end
            D_KEY: begin
                drain_state_s = D_WAIT;
            end
            D_WAIT: begin
                if (pp_done) begin
                    drain_state_s = D_IDLE;
                    free_s        = 1'b1;
                end else if (data_req) begin
                    // Requests beyond the last byte keep showing the last byte.
                    if (rd_idx_r != pp_num_r[IDX_W-1:0]) begin
                        rd_idx_s = rd_idx_r + IDX_W'(1'b1);
                    end else begin
                        rd_idx_s = rd_idx_r;
                    end
                end else begin
                    rd_idx_s = rd_idx_r;
                end
            end
            default: begin
                drain_state_s = D_IDLE;
            end
        endcase
    end

    // Bank data storage; contents are only meaningful once committed, so no reset.
    always_ff @(posedge system_clk) begin
        if (accept_s) begin
            mem_r[fill_bank_r][fill_cnt_r[IDX_W-1:0]] <= wr_data;
        end
    end

    // Bank full flags: set on commit, cleared on job completion (always different banks).
    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            bank_full_r <= 2'b00;
        end else begin
            if (commit_s) begin
                bank_full_r[fill_bank_r] <= 1'b1;
            end
            if (free_s) begin
                bank_full_r[drain_bank_r] <= 1'b0;
            end
        end
    end

    // Session and fill state: write pointer, fill count, bank descriptors, overflow.
    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            session_r      <= 1'b0;
            mode_r         <= 1'b0;
            overflow_r     <= 1'b0;
            fill_bank_r    <= 1'b0;
            fill_cnt_r     <= {CNT_W{1'b0}};
            wr_addr_r      <= {ADDR_W{1'b0}};
            bank_addr_r[0] <= {ADDR_W{1'b0}};
            bank_addr_r[1] <= {ADDR_W{1'b0}};
            bank_cnt_r[0]  <= {CNT_W{1'b0}};
            bank_cnt_r[1]  <= {CNT_W{1'b0}};
        end else if (start_ok_s) begin
            session_r   <= 1'b1;
            mode_r      <= mode_in;
            overflow_r  <= 1'b0;
            fill_bank_r <= 1'b0;
            fill_cnt_r  <= {CNT_W{1'b0}};
            wr_addr_r   <= base_addr;
        end else begin
            if (wr_en && !wr_ready_s) begin
                overflow_r <= 1'b1;
            end
            if (commit_s) begin
                bank_addr_r[fill_bank_r] <= wr_addr_r;
                bank_cnt_r[fill_bank_r]  <= cnt_after_s;
                wr_addr_r                <= wr_addr_r + ADDR_W'(cnt_after_s);
                fill_cnt_r               <= {CNT_W{1'b0}};
                fill_bank_r              <= ~fill_bank_r;
            end else begin
                fill_cnt_r <= cnt_after_s;
            end
        end
    end

    // Drain side registers: FSM state, read index and all job-facing outputs.
    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            drain_state_r <= D_IDLE;
            rd_idx_r      <= {IDX_W{1'b0}};
            drain_bank_r  <= 1'b0;
            pp_key_r      <= 1'b0;
            pp_addr_r     <= {ADDR_W{1'b0}};
            pp_num_r      <= 9'd0;
            pp_mode_r     <= 1'b0;
            pp_data_r     <= 8'd0;
            page_cnt_r    <= 16'd0;
        end else begin
            drain_state_r <= drain_state_s;
            rd_idx_r      <= rd_idx_s;
            pp_key_r      <= (drain_state_s == D_KEY);
            if (load_s) begin
                pp_addr_r <= bank_addr_r[drain_bank_r];
                pp_num_r  <= 9'(bank_cnt_r[drain_bank_r] - CNT_W'(1'b1));
                pp_mode_r <= mode_r;
            end
            // Pre-fetch so the byte is on pp_data in the cycle after key/data_req.
            if (drain_state_s != D_IDLE) begin
                pp_data_r <= mem_r[drain_bank_r][rd_idx_s];
            end
            if (start_ok_s) begin
                drain_bank_r <= 1'b0;
                page_cnt_r   <= 16'd0;
            end else if (free_s) begin
                drain_bank_r <= ~drain_bank_r;
                page_cnt_r   <= page_cnt_r + 16'd1;
            end
        end
    end

    assign wr_ready = wr_ready_s;
    assign busy     = session_r || (bank_full_r != 2'b00) || (drain_state_r != D_IDLE);
    assign pp_key   = pp_key_r;
    assign pp_addr  = pp_addr_r;
    assign pp_num   = pp_num_r;
    assign pp_mode  = pp_mode_r;
    assign pp_data  = pp_data_r;
    assign page_cnt = page_cnt_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_flash_pp_page_feeder.sv
// Scoreboard bench for flash_pp_page_feeder. The stimulus process pushes the
// expected jobs and bytes; a monitor process acting as flash_pp_ctrl pops and
// compares them whenever the DUT raises pp_key and as it steps through the data.
module tb_flash_pp_page_feeder;

    logic        system_clk;
    logic        system_reset_n;
    logic        start;
    logic [31:0] base_addr;
    logic        mode_in;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        flush;
    logic        pp_key;
    logic [31:0] pp_addr;
    logic [8:0]  pp_num;
    logic        pp_mode;
    logic [7:0]  pp_data;
    logic        data_req;
    logic        pp_done;
    logic        busy;
    logic [15:0] page_cnt;
    logic        overflow;

    flash_pp_page_feeder #(.PAGE_BYTES(256), .ADDR_W(32)) dut (
        .system_clk     (system_clk),
        .system_reset_n (system_reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .mode_in        (mode_in),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .flush          (flush),
        .pp_key         (pp_key),
        .pp_addr        (pp_addr),
        .pp_num         (pp_num),
        .pp_mode        (pp_mode),
        .pp_data        (pp_data),
        .data_req       (data_req),
        .pp_done        (pp_done),
        .busy           (busy),
        .page_cnt       (page_cnt),
        .overflow       (overflow)
    );

    typedef struct {
        logic [31:0] addr;
        logic [8:0]  num;
        logic        mode;
        bit          abort;
    } job_t;

    job_t        exp_job_q[$];
    logic [7:0]  exp_byte_q[$];

    int checks       = 0;
    int errors       = 0;
    int jobs_done    = 0;
    int key_count    = 0;
    int session_base = 0;
    int done_delay   = 3;
    bit mon_busy     = 1'b0;
    bit abort_armed  = 1'b0;
    bit stray_req    = 1'b0;
    bit stray_sent   = 1'b0;

    initial system_clk = 1'b0;
    always #10 system_clk = ~system_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_byte(output logic [7:0] b);
        if (exp_byte_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL byte_queue: actual=empty expected=a queued byte");
            b = 8'h00;
        end else begin
            b = exp_byte_q.pop_front();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_ready"}, 64'(wr_ready), 64'd0);
        check({tag, "_pp_key"},   64'(pp_key),   64'd0);
        check({tag, "_pp_addr"},  64'(pp_addr),  64'd0);
        check({tag, "_pp_num"},   64'(pp_num),   64'd0);
        check({tag, "_pp_mode"},  64'(pp_mode),  64'd0);
        check({tag, "_pp_data"},  64'(pp_data),  64'd0);
        check({tag, "_busy"},     64'(busy),     64'd0);
        check({tag, "_page_cnt"}, 64'(page_cnt), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    // Monitor / flash controller model: consumes expected jobs on each pp_key.
    initial begin
        job_t       job;
        logic [7:0] b;
        logic [7:0] last_b;
        int         t;
        data_req = 1'b0;
        pp_done  = 1'b0;
        forever begin
            @(negedge system_clk);
            if (pp_key === 1'b1) begin
                mon_busy = 1'b1;
                key_count++;
                if (exp_job_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key: actual pp_key=1 addr=0x%0h expected no job", pp_addr);
                end else begin
                    job = exp_job_q.pop_front();
                    check("job_addr", 64'(pp_addr), 64'(job.addr));
                    check("job_num",  64'(pp_num),  64'(job.num));
                    check("job_mode", 64'(pp_mode), 64'(job.mode));
                    if (job.abort) begin
                        @(negedge system_clk);
                        data_req = 1'b1;
                        repeat (3) @(negedge system_clk);
                        data_req    = 1'b0;
                        abort_armed = 1'b1;
                        t = 0;
                        while (!stray_req && t < 5000) begin
                            @(negedge system_clk);
                            t++;
                        end
                        pp_done = 1'b1;
                        @(negedge system_clk);
                        pp_done    = 1'b0;
                        stray_sent = 1'b1;
                    end else begin
                        pop_byte(b);
                        check("pp_data_first", 64'(pp_data), 64'(b));
                        last_b = b;
                        @(negedge system_clk);
                        check("pp_key_one_cycle", 64'(pp_key), 64'd0);
                        data_req = 1'b1;
                        for (int i = 1; i <= int'(job.num); i++) begin
                            @(negedge system_clk);
                            pop_byte(b);
                            check("pp_data", 64'(pp_data), 64'(b));
                            last_b = b;
                        end
                        @(negedge system_clk);
                        check("pp_data_saturate", 64'(pp_data), 64'(last_b));
                        data_req = 1'b0;
                        repeat (done_delay) @(negedge system_clk);
                        pp_done = 1'b1;
                        @(negedge system_clk);
                        pp_done = 1'b0;
                        jobs_done++;
                        check("page_cnt", 64'(page_cnt), 64'(16'(jobs_done - session_base)));
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic do_start(input logic [31:0] a, input logic m);
        @(negedge system_clk);
        start        = 1'b1;
        base_addr    = a;
        mode_in      = m;
        session_base = jobs_done;
        @(negedge system_clk);
        start = 1'b0;
    endtask

    task automatic push_job(input logic [31:0] a, input logic [8:0] n, input logic m, input bit ab);
        job_t j;
        j.addr  = a;
        j.num   = n;
        j.mode  = m;
        j.abort = ab;
        exp_job_q.push_back(j);
    endtask

    task automatic send(input int n, input logic [7:0] first, input bit flush_last, input bit keep);
        for (int i = 0; i < n; i++) begin
            @(negedge system_clk);
            check("wr_ready", 64'(wr_ready), 64'd1);
            wr_en   = 1'b1;
            wr_data = first + 8'(i);
            flush   = flush_last && (i == n - 1);
            if (keep) exp_byte_q.push_back(first + 8'(i));
        end
        @(negedge system_clk);
        wr_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(posedge system_clk);
            #1;
            t++;
        end while ((exp_job_q.size() != 0 || mon_busy) && t < 20000);
        check("idle_timeout", 64'(t < 20000), 64'd1);
    endtask

    // Directed stimulus.
    initial begin
        int t;
        int kb;
        system_reset_n = 1'b0;
        start          = 1'b0;
        base_addr      = 32'h0;
        mode_in        = 1'b0;
        wr_en          = 1'b0;
        wr_data        = 8'h00;
        flush          = 1'b0;
        #5;
        check_all_zero("reset");
        @(negedge system_clk);
        @(negedge system_clk);
        system_reset_n = 1'b1;

        // Aligned full page, mode PP.
        do_start(32'h0000_1000, 1'b0);
        check("busy_session", 64'(busy), 64'd1);
        check("page_cnt_start", 64'(page_cnt), 64'd0);
        push_job(32'h0000_1000, 9'd255, 1'b0, 1'b0);
        send(256, 8'h10, 1'b0, 1'b1);
        wait_idle();

        // Unaligned base splits at the page boundary, mode PPx4.
        do_start(32'h0000_2080, 1'b1);
        push_job(32'h0000_2080, 9'd127, 1'b1, 1'b0);
        push_job(32'h0000_2100, 9'd127, 1'b1, 1'b0);
        send(256, 8'hA0, 1'b1, 1'b1);
        wait_idle();

        // Both banks full with slow completion: back-pressure and overflow.
        done_delay = 2000;
        do_start(32'h0000_3000, 1'b0);
        push_job(32'h0000_3000, 9'd255, 1'b0, 1'b0);
        push_job(32'h0000_3100, 9'd255, 1'b0, 1'b0);
        push_job(32'h0000_3200, 9'd87,  1'b0, 1'b0);
        send(512, 8'h00, 1'b0, 1'b1);
        check("wr_ready_both_full", 64'(wr_ready), 64'd0);
        check("overflow_before", 64'(overflow), 64'd0);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        @(negedge system_clk);
        wr_en = 1'b0;
        check("overflow_set", 64'(overflow), 64'd1);
        t = 0;
        while (!wr_ready && t < 5000) begin
            @(negedge system_clk);
            t++;
        end
        check("wr_ready_return_timeout", 64'(t < 5000), 64'd1);
        send(88, 8'h00, 1'b0, 1'b1);
        @(negedge system_clk);
        flush = 1'b1;
        @(negedge system_clk);
        flush = 1'b0;
        wait_idle();
        check("overflow_sticky", 64'(overflow), 64'd1);
        done_delay = 3;

        // Flush together with a byte, then flush of an empty bank.
        do_start(32'h0000_4000, 1'b0);
        check("overflow_cleared", 64'(overflow), 64'd0);
        push_job(32'h0000_4000, 9'd5, 1'b0, 1'b0);
        send(6, 8'h50, 1'b1, 1'b1);
        wait_idle();
        kb = key_count;
        @(negedge system_clk);
        flush = 1'b1;
        @(negedge system_clk);
        flush = 1'b0;
        repeat (20) @(negedge system_clk);
        check("empty_flush_no_key", 64'(key_count), 64'(kb));

        // Reset in the middle of a job, stray pp_done, then a fresh session.
        do_start(32'h0000_5000, 1'b1);
        push_job(32'h0000_5000, 9'd255, 1'b1, 1'b1);
        send(256, 8'h33, 1'b0, 1'b0);
        t = 0;
        while (!abort_armed && t < 2000) begin
            @(negedge system_clk);
            t++;
        end
        check("abort_arm_timeout", 64'(t < 2000), 64'd1);
        kb = key_count;
        @(negedge system_clk);
        #2;
        system_reset_n = 1'b0;
        #1;
        check_all_zero("midjob_reset");
        @(negedge system_clk);
        system_reset_n = 1'b1;
        stray_req = 1'b1;
        t = 0;
        while (!stray_sent && t < 6000) begin
            @(negedge system_clk);
            t++;
        end
        check("stray_done_timeout", 64'(t < 6000), 64'd1);
        repeat (5) @(negedge system_clk);
        check("stray_page_cnt", 64'(page_cnt), 64'd0);
        check("stray_busy", 64'(busy), 64'd0);
        check("stray_no_key", 64'(key_count), 64'(kb));
        do_start(32'h0000_6000, 1'b1);
        push_job(32'h0000_6000, 9'd4, 1'b1, 1'b0);
        send(5, 8'hC0, 1'b1, 1'b1);
        wait_idle();
        check("fresh_page_cnt", 64'(page_cnt), 64'd1);
        check("bytes_consumed", 64'(exp_byte_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_pp_page_feeder.md
Name: flash_pp_page_feeder

Overview:
- Upstream stage for flash_pp_ctrl: gathers a host byte stream into flash pages and issues page-program jobs.
- Two 256-byte banks in ping-pong: host fills one bank while flash_pp_ctrl drains the other.
- Per job, drives flash_pp_ctrl's key/addr/pp_num/mode inputs and serves its data bytes on request.
- Splits jobs so no program crosses a 256-byte flash page boundary.

Parameters:
- PAGE_BYTES, 256, bank depth and flash page size (power of 2, max 256).
- ADDR_W, 32, flash address width.

Ports:
- system_clk  input  1  system clock (50 MHz).
- system_reset_n  input  1  asynchronous active-low reset.
- start  input  1  1-cycle pulse: begin a session at base_addr.
- base_addr  input  ADDR_W  first flash byte address of the session.
- mode_in  input  1  0 = PP, 1 = PPx4; sampled at start.
- wr_en  input  1  host byte strobe.
- wr_data  input  8  host byte.
- wr_ready  output  1  a fill bank is available.
- flush  input  1  1-cycle pulse: commit a partial bank.
- pp_key  output  1  1-cycle job trigger to flash_pp_ctrl.key.
- pp_addr  output  ADDR_W  job start address.
- pp_num  output  9  job byte count minus 1.
- pp_mode  output  1  to flash_pp_ctrl.mode.
- pp_data  output  8  current job byte.
- data_req  input  1  1-cycle pulse from flash_pp_ctrl: advance to next byte.
- pp_done  input  1  job-complete pulse from flash_pp_ctrl.
- busy  output  1  session active, or any bank full, or a job outstanding.
- page_cnt  output  16  jobs completed since start (wraps at 16 bits).
- overflow  output  1  sticky: a byte was dropped.

Behaviour:
- Reset (async, any time, including mid-job): all outputs 0, both banks empty, fill and drain FSMs idle, session inactive.
- Any pp_done arriving after reset is ignored.
- start:
  - Accepted only when no bank is full and no job is outstanding; otherwise ignored.
  - On accept: wr_addr <= base_addr, mode latched, page_cnt <= 0, overflow <= 0, fill bank <= 0, session active.
- Fill capacity:
  - cap = PAGE_BYTES - wr_addr[7:0].
  - An unaligned base therefore yields a short first job; all later jobs are page aligned.
- Fill:
  - wr_ready = session active AND fill bank not full.
  - Each accepted wr_en writes wr_data at index fill_cnt, then fill_cnt++.
  - When fill_cnt reaches cap, in the same cycle: bank marked full with {addr = wr_addr, count = cap}; wr_addr += cap; fill switches to the other bank.
  - The full bank becomes available to drain on the next cycle.
- flush:
  - With fill_cnt > 0: commit fill_cnt bytes as above.
  - With fill_cnt = 0: no-op.
  - wr_en and flush in the same cycle: the byte is included, then committed.
- wr_en while wr_ready = 0: byte dropped, overflow <= 1 (sticky until next start).
- Drain FSM states D_IDLE, D_KEY, D_WAIT:
  - D_IDLE -> D_KEY when the oldest full bank exists; banks are drained in commit order.
    - Load pp_addr, pp_num = count - 1, pp_mode; byte index <= 0.
  - D_KEY: pp_key = 1 for exactly one cycle; pp_data = byte 0 is valid in this cycle. Then -> D_WAIT.
  - D_WAIT, data_req: index++; pp_data shows the new byte the next cycle.
    - data_req past count - 1: pp_data holds the last byte; index saturates.
  - D_WAIT, pp_done: bank freed, page_cnt++, -> D_IDLE.
    - Next job key no earlier than 2 cycles after pp_done.
  - pp_done in D_IDLE or D_KEY: ignored.
- Simultaneous events:
  - Bank freed and fill commit in the same cycle: both take effect.
  - wr_ready reasserts the cycle after the free.
- Session end: session stays active until the next start.
  - A new start also re-arms after reset.
- Outputs pp_addr, pp_num, pp_mode hold their values between jobs.

Test Plan:
- Start base 0x1000, mode 0, stream 256 bytes 0x10..0x0F (wrapping) -> one pp_key, pp_addr 0x1000, pp_num 255. pp_data sequence over 255 data_req matches the stream. page_cnt 1 after pp_done.
- Start base 0x2080, stream 256 bytes, mode 1 -> job1 addr 0x2080 pp_num 127; job2 addr 0x2100 pp_num 127. pp_mode 1 on both.
- Stream 600 bytes at base 0x3000 with pp_done delayed 2000 cycles -> wr_ready drops after 512 bytes. 1 extra write sets overflow. Jobs at 0x3000 and 0x3100, 256 bytes each; third job after final flush at 0x3200 with the correct count.
- Write 5 bytes then flush with wr_en on the same cycle -> job pp_num 5. flush with an empty bank -> no pp_key.
- Assert system_reset_n low in D_WAIT mid-job -> all outputs 0 immediately. A later pp_done is ignored. A fresh start works normally.
